// File: rtl/sm83_pkg.sv
// sm83_pkg: shared types and constants for the SM83 decode stage.
//   ctl_op_t    - operation handed to the control sequencer
//   dec_state_t - instruction-register context state (OP/PREFIX/CB_OP/INT/LOCKED)
//   alu_op_t    - ALU operation field ir[5:3]
//   R8_*        - r8 register index constants
//   is_illegal_opcode() - membership test for the SM83 hole opcodes
package sm83_pkg;

  typedef enum logic [3:0] {
    CTL_NOP          = 4'd0,
    CTL_HALT         = 4'd1,
    CTL_LD_R8_D8     = 4'd2,
    CTL_LD_R8_R8     = 4'd3,
    CTL_LDPTR_R8_HL  = 4'd4,
    CTL_STPTR_HL_R8  = 4'd5,
    CTL_ALU_R8       = 4'd6,
    CTL_ALU_HL       = 4'd7,
    CTL_CB_PREFIX    = 4'd8,
    CTL_CB_R8        = 4'd9,
    CTL_CB_HL        = 4'd10,
    CTL_INT_DISPATCH = 4'd11,
    CTL_ILLEGAL      = 4'd12,
    CTL_UNIMPL       = 4'd13
  } ctl_op_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_ADC = 3'd1,
    ALU_SUB = 3'd2,
    ALU_SBC = 3'd3,
    ALU_AND = 3'd4,
    ALU_XOR = 3'd5,
    ALU_OR  = 3'd6,
    ALU_CP  = 3'd7
  } alu_op_t;

  // Decode state kept as plain constants so older tooling can match encodings.
  typedef logic [2:0] dec_state_t;
  localparam dec_state_t ST_OP     = 3'd0;
  localparam dec_state_t ST_PREFIX = 3'd1;
  localparam dec_state_t ST_CB_OP  = 3'd2;
  localparam dec_state_t ST_INT    = 3'd3;
  localparam dec_state_t ST_LOCKED = 3'd4;

  localparam logic [2:0] R8_B     = 3'd0;
  localparam logic [2:0] R8_C     = 3'd1;
  localparam logic [2:0] R8_D     = 3'd2;
  localparam logic [2:0] R8_E     = 3'd3;
  localparam logic [2:0] R8_H     = 3'd4;
  localparam logic [2:0] R8_L     = 3'd5;
  localparam logic [2:0] R8_HLPTR = 3'd6;
  localparam logic [2:0] R8_A     = 3'd7;

  localparam logic [7:0] OPC_NOP       = 8'h00;
  localparam logic [7:0] OPC_HALT      = 8'h76;
  localparam logic [7:0] OPC_CB_PREFIX = 8'hCB;

  function automatic logic is_illegal_opcode(input logic [7:0] op);
    logic hit;
    case (op)
      8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB,
      8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD: hit = 1'b1;
      default:                           hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/sm83_opcode_table.sv
// sm83_opcode_table: purely combinational (state, ir) -> control decode.
// Ports:
//   state    in  dec_state_t  current decode context
//   ir       in  8            latched instruction byte
//   ctl_op   out ctl_op_t     sequencer operation
//   r8_dst   out 3            destination r8 index
//   r8_src   out 3            source r8 index
//   alu_op   out alu_op_t     ir[5:3] for ALU/CB ops, else ALU_ADD
//   cb_group out 2            ir[7:6] in CB_OP, else 0
module sm83_opcode_table
  import sm83_pkg::*;
(
  input  dec_state_t  state,
  input  logic [7:0]  ir,
  output ctl_op_t     ctl_op,
  output logic [2:0]  r8_dst,
  output logic [2:0]  r8_src,
  output alu_op_t     alu_op,
  output logic [1:0]  cb_group
);

  // Opcode/context decode; every path starts from all-zero selects.
  always_comb begin
    ctl_op   = CTL_UNIMPL;
    r8_dst   = R8_B;
    r8_src   = R8_B;
    alu_op   = ALU_ADD;
    cb_group = 2'd0;
    case (state)
      ST_OP: begin
        // Illegal opcodes only reach OP when lockup is disabled; they act as NOP.
        if ((ir == OPC_NOP) || is_illegal_opcode(ir)) begin
          ctl_op = CTL_NOP;
        end else if (ir == OPC_HALT) begin
          ctl_op = CTL_HALT;
        end else begin
          case (ir[7:6])
            2'b00: begin
              if ((ir[2:0] == R8_HLPTR) && (ir[5:3] != R8_HLPTR)) begin
                ctl_op = CTL_LD_R8_D8;
                r8_dst = ir[5:3];
              end else begin
                ctl_op = CTL_UNIMPL;
              end
            end
            2'b01: begin
              r8_dst = ir[5:3];
              r8_src = ir[2:0];
              if (ir[2:0] == R8_HLPTR) begin
                ctl_op = CTL_LDPTR_R8_HL;
              end else if (ir[5:3] == R8_HLPTR) begin
                ctl_op = CTL_STPTR_HL_R8;
              end else begin
                ctl_op = CTL_LD_R8_R8;
              end
            end
            2'b10: begin
              alu_op = alu_op_t'(ir[5:3]);
              r8_src = ir[2:0];
              r8_dst = R8_A;
              if (ir[2:0] == R8_HLPTR) begin
                ctl_op = CTL_ALU_HL;
              end else begin
                ctl_op = CTL_ALU_R8;
              end
            end
            default: ctl_op = CTL_UNIMPL;
          endcase
        end
      end
      ST_PREFIX: ctl_op = CTL_CB_PREFIX;
      ST_CB_OP: begin
        r8_dst   = ir[2:0];
        r8_src   = ir[2:0];
        alu_op   = alu_op_t'(ir[5:3]);
        cb_group = ir[7:6];
        if (ir[2:0] == R8_HLPTR) begin
          ctl_op = CTL_CB_HL;
        end else begin
          ctl_op = CTL_CB_R8;
        end
      end
      ST_INT:    ctl_op = CTL_INT_DISPATCH;
      ST_LOCKED: ctl_op = CTL_ILLEGAL;
      default:   ctl_op = CTL_UNIMPL;
    endcase
  end

endmodule

// File: rtl/ir_decode.sv
// ir_decode: SM83 instruction register, CB/interrupt context FSM and lockup.
// Ports:
//   clk, rst_n  core clock, asynchronous active-low reset
//   mem_to_ir   fetch strobe; data_in sampled on this posedge
//   data_in     memory read data
//   int_req     any enabled interrupt pending (level)
//   ime         interrupt master enable
//   ctl_op, r8_dst, r8_src, alu_op, cb_group  decode of (state, ir)
//   int_ack     one-cycle pulse after an interrupt is accepted
//   locked      illegal-opcode lockup
module ir_decode
  import sm83_pkg::*;
#(
  parameter bit ILLEGAL_LOCK = 1'b1,
  parameter bit INT_EN       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_to_ir,
  input  logic [7:0]  data_in,
  input  logic        int_req,
  input  logic        ime,
  output ctl_op_t     ctl_op,
  output logic [2:0]  r8_dst,
  output logic [2:0]  r8_src,
  output alu_op_t     alu_op,
  output logic [1:0]  cb_group,
  output logic        int_ack,
  output logic        locked
);

  dec_state_t state_r;
  dec_state_t state_nxt_s;
  logic [7:0] ir_r;
  logic [7:0] ir_nxt_s;
  logic       int_ack_r;
  logic       int_ack_nxt_s;
  logic       take_int_s;

  assign take_int_s = INT_EN && int_req && ime;

  // Next-state / next-IR selection on a fetch strobe.
  always_comb begin
    state_nxt_s   = state_r;
    ir_nxt_s      = ir_r;
    int_ack_nxt_s = 1'b0;
    if (mem_to_ir && (state_r != ST_LOCKED)) begin
      if (state_r == ST_PREFIX) begin
        // The CB operand byte is never pre-empted by an interrupt.
        ir_nxt_s    = data_in;
        state_nxt_s = ST_CB_OP;
      end else if (take_int_s) begin
        // Fetched byte is dropped; IR keeps the previous opcode.
        state_nxt_s   = ST_INT;
        int_ack_nxt_s = 1'b1;
      end else if (data_in == OPC_CB_PREFIX) begin
        ir_nxt_s    = OPC_CB_PREFIX;
        state_nxt_s = ST_PREFIX;
      end else if (ILLEGAL_LOCK && is_illegal_opcode(data_in)) begin
        ir_nxt_s    = data_in;
        state_nxt_s = ST_LOCKED;
      end else begin
        ir_nxt_s    = data_in;
        state_nxt_s = ST_OP;
      end
    end else begin
      state_nxt_s = state_r;
    end
  end

  // IR, decode state and interrupt-acknowledge registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_OP;
      ir_r      <= OPC_NOP;
      int_ack_r <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      ir_r      <= ir_nxt_s;
      int_ack_r <= int_ack_nxt_s;
    end
  end

  sm83_opcode_table u_table (
    .state    (state_r),
    .ir       (ir_r),
    .ctl_op   (ctl_op),
    .r8_dst   (r8_dst),
    .r8_src   (r8_src),
    .alu_op   (alu_op),
    .cb_group (cb_group)
  );

  assign int_ack = int_ack_r;
  assign locked  = (state_r == ST_LOCKED);

endmodule

// File: tb/tb_ir_decode.sv
// tb_ir_decode: directed table plus randomized run for ir_decode, with a
// behavioural model of the fetch/decode rules. Two instances share stimulus:
// u_dut (lockup enabled) and u_dut_nl (illegal opcodes act as NOP).
module tb_ir_decode;
  import sm83_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       mem_to_ir = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       int_req = 1'b0;
  logic       ime = 1'b0;

  ctl_op_t    ctl0, ctl1;
  logic [2:0] dst0, dst1, src0, src1;
  alu_op_t    alu0, alu1;
  logic [1:0] grp0, grp1;
  logic       ack0, ack1, lck0, lck1;

  int total = 0;
  int bad = 0;

  // model state per instance: 0 OP, 1 PREFIX, 2 CB_OP, 3 INT, 4 LOCKED
  int         m_st [2];
  logic [7:0] m_ir [2];
  logic       m_ack[2];

  always #5 clk = ~clk;

  ir_decode #(.ILLEGAL_LOCK(1'b1), .INT_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_to_ir(mem_to_ir), .data_in(data_in),
    .int_req(int_req), .ime(ime), .ctl_op(ctl0), .r8_dst(dst0), .r8_src(src0),
    .alu_op(alu0), .cb_group(grp0), .int_ack(ack0), .locked(lck0));

  ir_decode #(.ILLEGAL_LOCK(1'b0), .INT_EN(1'b1)) u_dut_nl (
    .clk(clk), .rst_n(rst_n), .mem_to_ir(mem_to_ir), .data_in(data_in),
    .int_req(int_req), .ime(ime), .ctl_op(ctl1), .r8_dst(dst1), .r8_src(src1),
    .alu_op(alu1), .cb_group(grp1), .int_ack(ack1), .locked(lck1));

  function automatic bit ill(input int v);
    return v inside {'hD3, 'hDB, 'hDD, 'hE3, 'hE4, 'hEB, 'hEC, 'hED, 'hF4, 'hFC, 'hFD};
  endfunction

  task automatic cmp(input string name, input int idx, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s [%0d] got=%0d expected=%0d at t=%0t", name, idx, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_st[k] = 0; m_ir[k] = 8'h00; m_ack[k] = 1'b0;
    end
  endfunction

  function automatic void model_clock(input logic m, input logic [7:0] d,
                                      input logic iq, input logic ie);
    for (int k = 0; k < 2; k++) begin
      m_ack[k] = 1'b0;
      if (m && m_st[k] != 4) begin
        if (m_st[k] == 1) begin
          m_ir[k] = d; m_st[k] = 2;
        end else if (iq && ie) begin
          m_st[k] = 3; m_ack[k] = 1'b1;
        end else if (d == 8'hCB) begin
          m_ir[k] = d; m_st[k] = 1;
        end else if (ill(d) && k == 0) begin
          m_ir[k] = d; m_st[k] = 4;
        end else begin
          m_ir[k] = d; m_st[k] = 0;
        end
      end
    end
  endfunction

  // Expected decode from the opcode-map rules, computed arithmetically.
  task automatic model_out(input int k, output int ctl, output int dst,
                           output int src, output int alu, output int grp);
    int v;
    v = int'(m_ir[k]);
    ctl = int'(CTL_UNIMPL); dst = 0; src = 0; alu = 0; grp = 0;
    case (m_st[k])
      1: ctl = int'(CTL_PREFIX_CODE());
      2: begin
        grp = v / 64; alu = (v / 8) % 8; dst = v % 8; src = v % 8;
        ctl = (v % 8 == 6) ? int'(CTL_CB_HL) : int'(CTL_CB_R8);
      end
      3: ctl = int'(CTL_INT_DISPATCH);
      4: ctl = int'(CTL_ILLEGAL);
      default: begin
        if (v == 0 || ill(v)) ctl = int'(CTL_NOP);
        else if (v == 'h76) ctl = int'(CTL_HALT);
        else if (v < 'h40) begin
          if (v % 8 == 6 && v / 8 != 6) begin
            ctl = int'(CTL_LD_R8_D8); dst = v / 8;
          end
        end else if (v < 'h80) begin
          dst = (v / 8) % 8; src = v % 8;
          if (src == 6) ctl = int'(CTL_LDPTR_R8_HL);
          else if (dst == 6) ctl = int'(CTL_STPTR_HL_R8);
          else ctl = int'(CTL_LD_R8_R8);
        end else if (v < 'hC0) begin
          alu = (v / 8) % 8; src = v % 8; dst = 7;
          ctl = (src == 6) ? int'(CTL_ALU_HL) : int'(CTL_ALU_R8);
        end
      end
    endcase
  endtask

  function automatic ctl_op_t CTL_PREFIX_CODE();
    return CTL_CB_PREFIX;
  endfunction

  task automatic check_models(input int idx);
    int c, d, s, a, g;
    model_out(0, c, d, s, a, g);
    cmp("lk_ctl", idx, int'(ctl0), c); cmp("lk_dst", idx, int'(dst0), d);
    cmp("lk_src", idx, int'(src0), s); cmp("lk_alu", idx, int'(alu0), a);
    cmp("lk_grp", idx, int'(grp0), g); cmp("lk_ack", idx, int'(ack0), int'(m_ack[0]));
    cmp("lk_locked", idx, int'(lck0), (m_st[0] == 4) ? 1 : 0);
    model_out(1, c, d, s, a, g);
    cmp("nl_ctl", idx, int'(ctl1), c); cmp("nl_dst", idx, int'(dst1), d);
    cmp("nl_src", idx, int'(src1), s); cmp("nl_alu", idx, int'(alu1), a);
    cmp("nl_grp", idx, int'(grp1), g); cmp("nl_ack", idx, int'(ack1), int'(m_ack[1]));
    cmp("nl_locked", idx, int'(lck1), 0);
  endtask

  // Inputs are set just after a posedge, sampled on the next, checked 1ns later.
  task automatic step(input int idx, input logic m, input logic [7:0] d,
                      input logic iq, input logic ie);
    mem_to_ir = m; data_in = d; int_req = iq; ime = ie;
    @(posedge clk);
    model_clock(m, d, iq, ie);
    #1;
    check_models(idx);
    mem_to_ir = 1'b0; int_req = 1'b0;
  endtask

  // Asserts reset between clock edges and checks the asynchronous effect.
  task automatic do_reset(input int idx);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_models(idx);
    cmp("rst_ctl", idx, int'(ctl0), int'(CTL_NOP));
    cmp("rst_locked", idx, int'(lck0), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_models(idx);
  endtask

  typedef struct {
    logic       m;
    logic [7:0] d;
    logic       iq;
    logic       ie;
    ctl_op_t    ctl;
    logic [2:0] dst;
    logic [2:0] src;
    logic [2:0] alu;
    logic [1:0] grp;
    logic       ack;
    logic       lck;
  } vec_t;

  vec_t       tbl[21];
  logic [7:0] ill_list[11];

  initial begin
    tbl[0]  = '{1'b1, 8'h3E, 1'b0, 1'b0, CTL_LD_R8_D8,     3'd7, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h78, 1'b0, 1'b0, CTL_LD_R8_R8,     3'd7, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'h7E, 1'b0, 1'b0, CTL_LDPTR_R8_HL,  3'd7, 3'd6, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'h86, 1'b0, 1'b0, CTL_ALU_HL,       3'd7, 3'd6, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'hCB, 1'b0, 1'b0, CTL_CB_PREFIX,    3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h7C, 1'b0, 1'b0, CTL_CB_R8,        3'd4, 3'd4, 3'd7, 2'd1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, CTL_NOP,          3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h00, 1'b1, 1'b1, CTL_INT_DISPATCH, 3'd0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 8'h00, 1'b0, 1'b0, CTL_INT_DISPATCH, 3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'hCB, 1'b0, 1'b0, CTL_CB_PREFIX,    3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'h46, 1'b1, 1'b1, CTL_CB_HL,        3'd6, 3'd6, 3'd0, 2'd1, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'h76, 1'b0, 1'b0, CTL_HALT,         3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 8'h70, 1'b0, 1'b0, CTL_STPTR_HL_R8,  3'd6, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 8'h36, 1'b0, 1'b0, CTL_UNIMPL,       3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[14] = '{1'b1, 8'h97, 1'b0, 1'b0, CTL_ALU_R8,       3'd7, 3'd7, 3'd2, 2'd0, 1'b0, 1'b0};
    tbl[15] = '{1'b1, 8'hC3, 1'b0, 1'b0, CTL_UNIMPL,       3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[16] = '{1'b1, 8'h06, 1'b1, 1'b0, CTL_LD_R8_D8,     3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b0};
    tbl[17] = '{1'b1, 8'hCB, 1'b1, 1'b1, CTL_INT_DISPATCH, 3'd0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b0};
    tbl[18] = '{1'b1, 8'hD3, 1'b0, 1'b0, CTL_ILLEGAL,      3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1};
    tbl[19] = '{1'b1, 8'h00, 1'b0, 1'b0, CTL_ILLEGAL,      3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1};
    tbl[20] = '{1'b1, 8'h00, 1'b1, 1'b1, CTL_ILLEGAL,      3'd0, 3'd0, 3'd0, 2'd0, 1'b0, 1'b1};
    ill_list = '{8'hD3, 8'hDB, 8'hDD, 8'hE3, 8'hE4, 8'hEB, 8'hEC, 8'hED, 8'hF4, 8'hFC, 8'hFD};

    model_reset();
    #3;
    do_reset(0);

    // Directed table against hand-derived expectations (lockup instance).
    for (int i = 0; i < 21; i++) begin
      step(i, tbl[i].m, tbl[i].d, tbl[i].iq, tbl[i].ie);
      cmp("tbl_ctl", i, int'(ctl0), int'(tbl[i].ctl));
      cmp("tbl_dst", i, int'(dst0), int'(tbl[i].dst));
      cmp("tbl_src", i, int'(src0), int'(tbl[i].src));
      cmp("tbl_alu", i, int'(alu0), int'(tbl[i].alu));
      cmp("tbl_grp", i, int'(grp0), int'(tbl[i].grp));
      cmp("tbl_ack", i, int'(ack0), int'(tbl[i].ack));
      cmp("tbl_locked", i, int'(lck0), int'(tbl[i].lck));
    end
    // Non-locking instance saw 0xD3 at row 18 and must have decoded it as NOP.
    cmp("nl_d3_state", 18, int'(lck1), 0);

    // Reset mid-LOCKED.
    #2;
    do_reset(100);

    // Reset mid-PREFIX.
    step(101, 1'b1, 8'hCB, 1'b0, 1'b0);
    cmp("pre_ctl", 101, int'(ctl0), int'(CTL_CB_PREFIX));
    #2;
    do_reset(102);

    // Non-locking instance decodes 0xD3 as NOP and keeps fetching.
    step(103, 1'b1, 8'hD3, 1'b0, 1'b0);
    cmp("nl_d3_ctl", 103, int'(ctl1), int'(CTL_NOP));
    cmp("nl_d3_lck", 103, int'(lck1), 0);
    #2;
    do_reset(104);

    // Randomized run against the model.
    for (int i = 0; i < 600; i++) begin
      int r;
      logic [7:0] d;
      if ($urandom_range(0, 99) < 2) begin
        #2;
        do_reset(1000 + i);
      end else begin
        r = $urandom_range(0, 9);
        if (r < 2) d = 8'hCB;
        else if (r == 2) d = ill_list[$urandom_range(0, 10)];
        else d = 8'($urandom_range(0, 255));
        step(1000 + i, ($urandom_range(0, 3) != 0), d,
             ($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ir_decode.md
Name: ir_decode

Overview:
Instruction register and decode stage directly upstream of the SM83 control sequencer. It latches opcode bytes from the memory data bus when the sequencer asserts mem_to_ir. It tracks CB-prefix and interrupt-dispatch context, and drives ctl_op, register selects and ALU op to the sequencer and datapath. It also owns the illegal-opcode lockup state.

Parameters:
ILLEGAL_LOCK, 1, 1: illegal opcodes lock the core until reset; 0: illegal opcodes decode as CTL_NOP.
INT_EN, 1, 0 ties off the interrupt path (int_ack never asserts).

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
mem_to_ir  in  1  fetch strobe from control; data_in is sampled on this posedge
data_in  in  8  memory read data bus
int_req  in  1  level; any enabled interrupt pending
ime  in  1  interrupt master enable
ctl_op  out  ctl_op_t  operation for the control sequencer
r8_dst  out  3  destination r8 index (B,C,D,E,H,L,(HL),A = 0..7)
r8_src  out  3  source r8 index
alu_op  out  alu_op_t  ir[5:3] for ALU/CB ops
cb_group  out  2  ir[7:6] when in CB_OP, else 0
int_ack  out  1  one-cycle pulse: interrupt accepted
locked  out  1  illegal-opcode lockup

Behaviour:
- ir[7:0] and state are registered. All decode outputs are a combinational function of (state, ir). Outputs are valid from the posedge that loaded IR and stable until the next load.
- Reset state:
  - ir=0x00, state=OP, so ctl_op=CTL_NOP and control fetches on its first cycle.
  - r8_dst=r8_src=0, alu_op=0, cb_group=0, int_ack=0, locked=0.
- States: OP, PREFIX, CB_OP, INT, LOCKED.
- Fetch from OP, CB_OP or INT (on a mem_to_ir edge):
  - If INT_EN && int_req && ime: go to INT; ir unchanged; int_ack=1 for exactly the following cycle; fetched byte discarded.
  - Else if data_in==0xCB: ir<=0xCB, go to PREFIX.
  - Else if data_in is illegal and ILLEGAL_LOCK: ir<=data_in, go to LOCKED.
  - Else: ir<=data_in, go to OP.
- Fetch from PREFIX: ir<=data_in, go to CB_OP. Interrupts are never taken in PREFIX.
- LOCKED: mem_to_ir ignored; exit only by reset.
- Illegal opcode set: D3, DB, DD, E3, E4, EB, EC, ED, F4, FC, FD.
- OP decode:
  - 00 -> CTL_NOP.
  - 76 -> CTL_HALT.
  - 00xxx110 -> CTL_LD_R8_D8 with dst=ir[5:3]; dst==6 -> CTL_UNIMPL.
  - 01dddsss (not 76):
    - sss==6 -> CTL_LDPTR_R8_HL.
    - ddd==6 -> CTL_STPTR_HL_R8.
    - else -> CTL_LD_R8_R8.
    - r8_dst=ddd, r8_src=sss.
  - 10ooosss -> CTL_ALU_R8 (sss==6 -> CTL_ALU_HL); alu_op=ooo, r8_src=sss, r8_dst=7.
  - All others -> CTL_UNIMPL.
  - With ILLEGAL_LOCK=0, illegal opcodes decode as CTL_NOP.
- PREFIX -> CTL_CB_PREFIX (control fetches the next byte immediately).
- CB_OP -> CTL_CB_R8 (ir[2:0]==6 -> CTL_CB_HL); r8_dst=r8_src=ir[2:0], alu_op=ir[5:3], cb_group=ir[7:6].
- INT -> CTL_INT_DISPATCH; selects 0.
- LOCKED -> CTL_ILLEGAL; locked=1.
- Simultaneous events: int_req rising on the same edge as fetch of 0xCB → interrupt wins; the CB byte is discarded.
- Reset mid-PREFIX or mid-LOCKED returns to OP/NOP asynchronously.

Decomposition:
- Add to sm83_pkg:
  - ctl_op_t new values: CTL_NOP, CTL_LD_R8_R8, CTL_STPTR_HL_R8, CTL_ALU_HL, CTL_CB_PREFIX, CTL_CB_R8, CTL_CB_HL, CTL_INT_DISPATCH, CTL_ILLEGAL, CTL_UNIMPL.
  - dec_state_t.
  - alu_op_t.
  - R8_B..R8_A, R8_HLPTR index constants.
- One combinational sub-module, sm83_opcode_table: (state, ir) -> ctl_op and selects. The ir_decode top holds only the IR, the FSM and int_ack.

Test Plan:
- Reset release -> ctl_op=CTL_NOP, locked=0, int_ack=0. Fetch 0x3E -> CTL_LD_R8_D8, r8_dst=7.
- Fetch 0x78 -> CTL_LD_R8_R8, dst=7, src=0. Fetch 0x7E -> CTL_LDPTR_R8_HL. Fetch 0x86 -> CTL_ALU_HL, alu_op=0.
- Fetch 0xCB -> CTL_CB_PREFIX. Fetch 0x7C -> CTL_CB_R8, cb_group=1, alu_op=7, src=4. Then fetch 0x00 -> CTL_NOP, cb_group=0.
- int_req=1, ime=1 at fetch in OP -> CTL_INT_DISPATCH, int_ack high exactly 1 cycle. Same stimulus in PREFIX -> no ack, CB_OP entered.
- Fetch 0xD3 -> CTL_ILLEGAL, locked=1, further fetches of 0x00 ignored. Async reset mid-cycle -> CTL_NOP. With ILLEGAL_LOCK=0, 0xD3 -> CTL_NOP, locked=0.
